ex_muldiv_seq: RTL and testbench

Iterative multiply/divide sequencer for the EX stage. It owns the RV32M operations (funct7 = 0000001 on R_type), which the single-cycle ALU cannot complete. It accepts one operation from the ID/EX register, holds the pipeline with a stall output for the duration, and presents the result alongside EX_MEM_ALUOUT for the EX/MEM mux. It runs a shift-add multiplier or restoring divider loop, with a sign fix-up and fast paths for RISC-V divide corner cases.

---
 rtl/ex_muldiv_seq.sv | 157 +++++++++++++++
 tb/tb_ex_muldiv_seq.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer for the EX stage (shift-add multiply, restoring divide).
// Optional build macro MULDIV_EARLY_OUT_EN: multiplies leave CALC once the remaining multiplier bits are zero.
module ex_muldiv_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      ID_EX_func,
  input  logic [XLEN-1:0] ID_EX_rs1,
  input  logic [XLEN-1:0] ID_EX_rs2,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] EX_MEM_MDOUT
);

  // state | meaning
  // IDLE  | waiting for start; fast-path divide corner cases resolved here
  // CALC  | one multiplier/quotient bit per cycle, counter counts down to 0
  // FIX   | sign fix-up and result select, EX_MEM_MDOUT written
  // DONE  | one-cycle done pulse, pipeline released
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

  state_t              state_q, state_d;
  logic [2:0]          func_q;
  logic                sign_res_q, sign_a_q;
  logic [XLEN-1:0]     opa_q, opb_q, rem_q, mdout_q;
  logic [2*XLEN-1:0]   prod_q;
  logic [CNT_W-1:0]    cnt_q;

  logic                is_div, a_signed, b_signed, neg_a, neg_b;
  logic [XLEN-1:0]     mag_a, mag_b, fast_res;
  logic                fast_dz, fast_ov, fast_path, calc_last;
  logic [XLEN:0]       mul_sum, rem_shift, rem_diff;
  logic [2*XLEN-1:0]   prod_al, prod_fx;
  logic [XLEN-1:0]     quo_fx, rem_fx, fix_res;

  // operand decode for the op being accepted
  always_comb begin
    is_div    = ID_EX_func[2];
    a_signed  = is_div ? ~ID_EX_func[0] : (ID_EX_func[1:0] != 2'b11);
    b_signed  = is_div ? ~ID_EX_func[0] : ~ID_EX_func[1];
    neg_a     = a_signed & ID_EX_rs1[XLEN-1];
    neg_b     = b_signed & ID_EX_rs2[XLEN-1];
    mag_a     = neg_a ? -ID_EX_rs1 : ID_EX_rs1;
    mag_b     = neg_b ? -ID_EX_rs2 : ID_EX_rs2;
    fast_dz   = is_div & (ID_EX_rs2 == '0);
    fast_ov   = is_div & ~ID_EX_func[0] & (ID_EX_rs1 == MIN_NEG) & (ID_EX_rs2 == ALL_ONES);
    fast_path = fast_dz | fast_ov;
    if (fast_dz) fast_res = ID_EX_func[1] ? ID_EX_rs1 : ALL_ONES;
    else         fast_res = ID_EX_func[1] ? '0 : MIN_NEG;
  end

  always_comb begin
    calc_last = (cnt_q == '0);
`ifdef MULDIV_EARLY_OUT_EN
    if (!func_q[2] && (opb_q[XLEN-1:1] == '0)) calc_last = 1'b1;
`endif
    mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (opb_q[0] ? {1'b0, opa_q} : '0);
    rem_shift = {rem_q, opa_q[XLEN-1]};
    rem_diff  = rem_shift - {1'b0, opb_q};
  end

  // early exit leaves the partial product cnt_q bits too high
  always_comb begin
`ifdef MULDIV_EARLY_OUT_EN
    prod_al = prod_q >> cnt_q;
`else
    prod_al = prod_q;
`endif
    prod_fx = sign_res_q ? -prod_al : prod_al;
    quo_fx  = sign_res_q ? -opa_q : opa_q;
    rem_fx  = sign_a_q ? -rem_q : rem_q;
    case (func_q)
      3'b000:                fix_res = prod_fx[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod_fx[2*XLEN-1:XLEN];
      3'b100, 3'b101:        fix_res = quo_fx;
      default:               fix_res = rem_fx;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = fast_path ? DONE : CALC;
      CALC: if (calc_last) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_comb begin
    stall = 1'b0;
    done  = 1'b0;
    case (state_q)
      IDLE:      stall = start;
      CALC, FIX: stall = 1'b1;
      DONE:      done  = 1'b1;
      default:   ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      func_q     <= '0;
      sign_res_q <= 1'b0;
      sign_a_q   <= 1'b0;
      opa_q      <= '0;
      opb_q      <= '0;
      rem_q      <= '0;
      prod_q     <= '0;
      cnt_q      <= '0;
      mdout_q    <= '0;
    end else if (!flush) begin
      case (state_q)
        IDLE: if (start) begin
          func_q     <= ID_EX_func;
          sign_res_q <= neg_a ^ neg_b;
          sign_a_q   <= neg_a;
          opa_q      <= mag_a;
          opb_q      <= mag_b;
          rem_q      <= '0;
          prod_q     <= '0;
          cnt_q      <= CNT_W'(XLEN-1);
          if (fast_path) mdout_q <= fast_res;
        end
        CALC: begin
          if (func_q[2]) begin
            opa_q <= {opa_q[XLEN-2:0], ~rem_diff[XLEN]};
            rem_q <= rem_diff[XLEN] ? rem_shift[XLEN-1:0] : rem_diff[XLEN-1:0];
          end else begin
            prod_q <= {mul_sum, prod_q[XLEN-1:1]};
            opb_q  <= opb_q >> 1;
          end
          if (!calc_last) cnt_q <= cnt_q - CNT_W'(1);
        end
        FIX: mdout_q <= fix_res;
        default: ;
      endcase
    end
  end

  assign EX_MEM_MDOUT = mdout_q;

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Directed self-checking bench for ex_muldiv_seq; honours MULDIV_EARLY_OUT_EN for multiply latencies.
module tb_ex_muldiv_seq;

  localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011;
  localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  func;
  logic [31:0] rs1, rs2;
  logic        stall, done;
  logic [31:0] mdout;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] last_res = '0;

  always #5 clk = ~clk;

  ex_muldiv_seq #(.XLEN(32), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush),
    .ID_EX_func(func), .ID_EX_rs1(rs1), .ID_EX_rs2(rs2),
    .stall(stall), .done(done), .EX_MEM_MDOUT(mdout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat_n, input int lat_e);
    int lat_exp, lat, gap;
    logic got;
`ifdef MULDIV_EARLY_OUT_EN
    lat_exp = lat_e;
`else
    lat_exp = lat_n;
`endif
    @(posedge clk); #1;
    start = 1'b1; func = f; rs1 = a; rs2 = b;
    @(negedge clk);
    check({tag, " stall_at_start"}, {31'b0, stall}, 32'd1);
    @(posedge clk); #1;
    start = 1'b0; rs1 = $urandom; rs2 = $urandom;
    lat = 1; got = 1'b0; gap = 0;
    repeat (60) begin
      @(negedge clk);
      if (done) begin got = 1'b1; break; end
      if (!stall) gap++;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " done_seen"}, {31'b0, got}, 32'd1);
    check({tag, " latency"}, 32'(lat), 32'(lat_exp));
    check({tag, " stall_gap"}, 32'(gap), 32'd0);
    check({tag, " stall_in_done"}, {31'b0, stall}, 32'd0);
    check({tag, " result"}, mdout, exp);
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, " done_pulse"}, {31'b0, done}, 32'd0);
    check({tag, " result_hold"}, mdout, exp);
    last_res = exp;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; func = '0; rs1 = '0; rs2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset stall", {31'b0, stall}, 32'd0);
    check("reset done", {31'b0, done}, 32'd0);
    check("reset mdout", mdout, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    do_op("mul 7*-3",        F_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 4);
    do_op("mulhu max*max",   F_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 34);
    do_op("mulh -1*-1",      F_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 34, 3);
    do_op("mulhsu -1*2",     F_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 34, 4);
    do_op("mul 3*5",         F_MUL,    32'd3,          32'd5,         32'd15,        34, 5);
    do_op("div -7/2",        F_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34, 34);
    do_op("rem -7/2",        F_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34, 34);
    do_op("divu 100/7",      F_DIVU,   32'd100,        32'd7,         32'd14,        34, 34);
    do_op("remu 100/7",      F_REMU,   32'd100,        32'd7,         32'd2,         34, 34);
    do_op("div 100/-7",      F_DIV,    32'd100,        32'hFFFF_FFF9, 32'hFFFF_FFF2, 34, 34);
    do_op("rem 100/-7",      F_REM,    32'd100,        32'hFFFF_FFF9, 32'd2,         34, 34);
    do_op("divu 10/0",       F_DIVU,   32'd10,         32'd0,         32'hFFFF_FFFF, 1, 1);
    do_op("rem 10/0",        F_REM,    32'd10,         32'd0,         32'd10,        1, 1);
    do_op("rem ovf",         F_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1, 1);
    do_op("div ovf",         F_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1, 1);

    // flush a divide in its tenth cycle
    @(posedge clk); #1;
    start = 1'b1; func = F_DIV; rs1 = 32'd100; rs2 = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin
      @(negedge clk);
      check("flush pre done", {31'b0, done}, 32'd0);
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush stall", {31'b0, stall}, 32'd0);
    check("flush done", {31'b0, done}, 32'd0);
    check("flush mdout", mdout, last_res);
    do_op("remu after flush", F_REMU, 32'd100, 32'd7, 32'd2, 34, 34);

    // start coincident with flush is dropped
    @(posedge clk); #1;
    start = 1'b1; flush = 1'b1; func = F_DIVU; rs1 = 32'd10; rs2 = 32'd0;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("dropped start stall", {31'b0, stall}, 32'd0);
      check("dropped start done", {31'b0, done}, 32'd0);
      check("dropped start mdout", mdout, last_res);
      @(posedge clk); #1;
    end

    // reset in the middle of a multiply
    start = 1'b1; func = F_MULHU; rs1 = 32'hFFFF_FFFF; rs2 = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midop rst stall", {31'b0, stall}, 32'd0);
    check("midop rst done", {31'b0, done}, 32'd0);
    check("midop rst mdout", mdout, 32'd0);
    repeat (20) begin
      @(negedge clk);
      check("post rst no done", {31'b0, done}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
